// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: default frame geometry,
// capture sequencer state encoding and the RGB565 -> RGB444 packing.
package cam_pkg;

    localparam int H_PIX     = 160;
    localparam int V_PIX     = 120;
    localparam int FRAME_PIX = H_PIX * V_PIX;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cam_state_t;

    // Keep the top bits of each colour channel: R[4:1], G[5:2], B[4:1].
    function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for the camera pin bundle plus registered edge detection.
// All outputs come from the same register stage, so pclk_rise lines up with its data.
module cam_sync_edge (
    input  logic       clk,
    input  logic       rst,
    input  logic       pclk,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] data,
    output logic       pclk_rise,
    output logic       vs_rise,
    output logic       vs_fall,
    output logic       line_valid,
    output logic [7:0] px_byte
);

    logic [10:0] meta;
    logic [10:0] sync;
    logic        pclk_d;
    logic        vs_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta       <= '0;
            sync       <= '0;
            pclk_d     <= 1'b0;
            vs_d       <= 1'b0;
            pclk_rise  <= 1'b0;
            vs_rise    <= 1'b0;
            vs_fall    <= 1'b0;
            line_valid <= 1'b0;
            px_byte    <= '0;
        end else begin
            meta       <= {pclk, vsync, href, data};
            sync       <= meta;
            pclk_d     <= sync[10];
            vs_d       <= sync[9];
            pclk_rise  <= sync[10] & ~pclk_d;
            vs_rise    <= sync[9] & ~vs_d;
            vs_fall    <= ~sync[9] & vs_d;
            line_valid <= sync[8];
            px_byte    <= sync[7:0];
        end
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Capture sequencer: aligns to camera vsync, packs RGB565 byte pairs into RGB444
// frame-buffer writes, and reports frame completion and short/long frame errors.
module cam_capture_ctrl #(
    parameter int H_PIX = 160,
    parameter int V_PIX = 120,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_single,
    input  logic          cmd_cont,
    input  logic          cmd_stop,
    input  logic          CAM_pclk,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic          busy,
    output logic          frame_done,
    output logic [7:0]    frame_cnt,
    output logic          err_short,
    output logic          err_long
);
    import cam_pkg::*;

    localparam logic [AW:0] FRAME_LIM = (AW+1)'(H_PIX * V_PIX);

    cam_state_t  state, state_next;
    logic        pclk_rise, vs_rise, vs_fall, href;
    logic [7:0]  px_byte;
    logic        mode_cont;
    logic        stop_pend;
    logic        phase;
    logic [7:0]  hi;
    logic [AW:0] addr;
    logic [AW:0] fill;
    logic        wr;
    logic        start;
    logic        pair_done;
    logic        has_room;

    cam_sync_edge u_sync (
        .clk        (clk),
        .rst        (rst),
        .pclk       (CAM_pclk),
        .vsync      (CAM_vsync),
        .href       (CAM_href),
        .data       (CAM_px_data),
        .pclk_rise  (pclk_rise),
        .vs_rise    (vs_rise),
        .vs_fall    (vs_fall),
        .line_valid (href),
        .px_byte    (px_byte)
    );

    // addr lags a write by one cycle; fill counts that in-flight write too.
    assign fill = addr + (AW+1)'(wr);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        pair_done  = (state == ST_CAPTURE) && pclk_rise && href && phase;
        has_room   = (fill < FRAME_LIM);
        case (state)
            ST_IDLE: begin
                if (!cmd_stop && (cmd_single || cmd_cont)) begin
                    state_next = ST_WAIT_VS;
                    start      = 1'b1;
                end
            end
            ST_WAIT_VS: begin
                if (cmd_stop)     state_next = ST_IDLE;
                else if (vs_fall) state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (vs_rise) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = (!mode_cont || stop_pend) ? ST_IDLE : ST_WAIT_VS;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_cont      <= 1'b0;
            stop_pend      <= 1'b0;
            phase          <= 1'b0;
            hi             <= '0;
            addr           <= '0;
            wr             <= 1'b0;
            DP_RAM_data_in <= '0;
            frame_done     <= 1'b0;
            frame_cnt      <= '0;
            err_short      <= 1'b0;
            err_long       <= 1'b0;
        end else begin
            if (start) begin
                mode_cont <= cmd_cont;
                err_short <= 1'b0;
                err_long  <= 1'b0;
            end else if (state != ST_IDLE && cmd_cont && !cmd_stop) begin
                mode_cont <= 1'b1;
            end

            if (state == ST_DONE)                      stop_pend <= 1'b0;
            else if (state == ST_CAPTURE && cmd_stop)  stop_pend <= 1'b1;

            if (wr) addr <= addr + (AW+1)'(1);

            if (state == ST_WAIT_VS && vs_fall && !cmd_stop) begin
                addr  <= '0;
                phase <= 1'b0;
            end else if (state == ST_CAPTURE) begin
                // A line ending on an odd byte leaves its hi byte unused.
                if (!href) begin
                    phase <= 1'b0;
                end else if (pclk_rise) begin
                    if (!phase) hi <= px_byte;
                    phase <= ~phase;
                end
            end

            wr <= pair_done && has_room;
            if (pair_done && has_room) DP_RAM_data_in <= DW'(rgb565_to_444(hi, px_byte));
            if (pair_done && !has_room) err_long <= 1'b1;
            if (state == ST_CAPTURE && vs_rise && has_room) err_short <= 1'b1;

            frame_done <= (state == ST_DONE);
            if (state == ST_DONE) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign DP_RAM_addr_in = addr[AW-1:0];
    assign DP_RAM_regW    = wr;
    assign busy           = (state != ST_IDLE);

endmodule
